// File: rtl/pll_clken_pkg.sv
// Shared types and constants for the fractional clock-enable generator.
// The phase-resync option (PLL_CLKEN_PHASE_RESYNC_EN) is handled in the top level.
package pll_clken_pkg;

  localparam int DEFAULT_ACC_WIDTH = 32;

  typedef enum logic {
    SETTLING = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  // Increment giving freq_hz from refclk_hz: freq * 2^width / refclk (truncated).
  function automatic logic [63:0] incr_for(input logic [63:0] freq_hz,
                                           input logic [63:0] refclk_hz,
                                           input int          width);
    logic [127:0] scaled;
    scaled = {64'd0, freq_hz} << width;
    return 64'(scaled / {64'd0, refclk_hz});
  endfunction

endpackage

// File: rtl/pll_clken_chan.sv
// One enable channel: phase accumulator, active/pending increment with
// boundary-aligned apply, registered enable strobe and square wave.
module pll_clken_chan
  import pll_clken_pkg::*;
#(
  parameter int ACC_WIDTH = DEFAULT_ACC_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wr_i,
  input  logic [ACC_WIDTH-1:0] wr_incr_i,
  input  logic                 sync_i,
  output logic                 en_o,
  output logic                 sq_o,
  output logic                 pending_o
);

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] incr_q, incr_d;
  logic [ACC_WIDTH-1:0] pend_incr_q, pend_incr_d;
  logic                 pend_q, pend_d;
  logic                 en_q, en_d;
  logic                 sq_q, sq_d;
  logic [ACC_WIDTH:0]   sum;
  logic                 stopped;
  logic                 apply;

  always_comb begin
    sum     = {1'b0, acc_q} + {1'b0, incr_q};
    stopped = (incr_q == '0);
    // A running channel only changes rate on its carry edge, so no period is cut or stretched.
    apply   = pend_q && (stopped || sum[ACC_WIDTH] || sync_i);

    acc_d = sum[ACC_WIDTH-1:0];
    if (sync_i || (pend_q && stopped)) begin
      acc_d = '0;
    end
    incr_d      = apply ? pend_incr_q : incr_q;
    pend_incr_d = wr_i ? wr_incr_i : pend_incr_q;
    pend_d      = wr_i || (pend_q && !apply);
    en_d        = sum[ACC_WIDTH] && !sync_i;
    sq_d        = sync_i ? 1'b0 : (sq_q ^ sum[ACC_WIDTH]);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q       <= '0;
      incr_q      <= '0;
      pend_incr_q <= '0;
      pend_q      <= 1'b0;
      en_q        <= 1'b0;
      sq_q        <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      incr_q      <= incr_d;
      pend_incr_q <= pend_incr_d;
      pend_q      <= pend_d;
      en_q        <= en_d;
      sq_q        <= sq_d;
    end
  end

  assign en_o      = en_q;
  assign sq_o      = sq_q;
  assign pending_o = pend_q;

endmodule

// File: rtl/pll_clken_gen.sv
// Multi-channel fractional clock-enable generator with write decode and lock FSM.
// Define PLL_CLKEN_PHASE_RESYNC_EN to add the sync_in phase-alignment strobe.
module pll_clken_gen
  import pll_clken_pkg::*;
#(
  parameter int NUM_CHANNELS  = 4,
  parameter int ACC_WIDTH     = DEFAULT_ACC_WIDTH,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                    refclk,
  input  logic                    rst,
  input  logic                    cfg_wr,
  input  logic [((NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1)-1:0] cfg_chan,
  input  logic [ACC_WIDTH-1:0]    cfg_incr,
`ifdef PLL_CLKEN_PHASE_RESYNC_EN
  input  logic                    sync_in,
`endif
  output logic [NUM_CHANNELS-1:0] outclk_en,
  output logic [NUM_CHANNELS-1:0] outclk_sq,
  output logic [NUM_CHANNELS-1:0] pending,
  output logic                    locked
);

  localparam int CHAN_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int CNT_W  = $clog2(SETTLE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic sync_w;
`ifdef PLL_CLKEN_PHASE_RESYNC_EN
  assign sync_w = sync_in;
`else
  assign sync_w = 1'b0;
`endif

  logic wr_valid;
  assign wr_valid = cfg_wr && (int'(cfg_chan) < NUM_CHANNELS);

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
    pll_clken_chan #(
      .ACC_WIDTH (ACC_WIDTH)
    ) u_chan (
      .clk_i     (refclk),
      .rst_i     (rst),
      .wr_i      (wr_valid && (cfg_chan == CHAN_W'(g))),
      .wr_incr_i (cfg_incr),
      .sync_i    (sync_w),
      .en_o      (outclk_en[g]),
      .sq_o      (outclk_sq[g]),
      .pending_o (pending[g])
    );
  end

  lock_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dirty;

  always_comb begin
    dirty   = wr_valid || (|pending) || sync_w;
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      SETTLING: begin
        if (dirty) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = LOCKED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LOCKED: begin
        if (wr_valid || sync_w) begin
          state_d = SETTLING;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q <= SETTLING;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign locked = (state_q == LOCKED);

endmodule

// File: tb/tb_pll_clken_gen.sv
// Bench for pll_clken_gen: directed timing checks plus randomized traffic
// compared every cycle against a per-channel arithmetic reference.
module tb_pll_clken_gen;
  import pll_clken_pkg::*;

  localparam int NC = 3;
  localparam int AW = 32;
  localparam int SC = 16;
  localparam longint unsigned MODV = 64'd1 << AW;

  logic          refclk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_wr = 1'b0;
  logic [1:0]    cfg_chan = 2'd0;
  logic [AW-1:0] cfg_incr = '0;
  logic          sync_in = 1'b0;
  logic [NC-1:0] outclk_en, outclk_sq, pending;
  logic          locked;

  always #5 refclk = ~refclk;

  pll_clken_gen #(
    .NUM_CHANNELS  (NC),
    .ACC_WIDTH     (AW),
    .SETTLE_CYCLES (SC)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .cfg_wr    (cfg_wr),
    .cfg_chan  (cfg_chan),
    .cfg_incr  (cfg_incr),
`ifdef PLL_CLKEN_PHASE_RESYNC_EN
    .sync_in   (sync_in),
`endif
    .outclk_en (outclk_en),
    .outclk_sq (outclk_sq),
    .pending   (pending),
    .locked    (locked)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: each channel is a number acc in [0, 2^AW); every cycle acc += incr,
  // and crossing 2^AW is a strobe. Lock = SC consecutive cycles with nothing outstanding.
  longint unsigned m_acc[NC], m_incr[NC], m_pincr[NC];
  bit              m_pend[NC], m_en[NC], m_sq[NC];
  int              m_streak;
  longint unsigned m_sum;
  bit              m_carry, m_apply, m_sync, m_valid, m_dirty;

  always @(posedge refclk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NC; c++) begin
        m_acc[c] = 0; m_incr[c] = 0; m_pincr[c] = 0;
        m_pend[c] = 0; m_en[c] = 0; m_sq[c] = 0;
      end
      m_streak = 0;
    end else begin
`ifdef PLL_CLKEN_PHASE_RESYNC_EN
      m_sync = sync_in;
`else
      m_sync = 1'b0;
`endif
      m_valid = cfg_wr && (int'(cfg_chan) < NC);
      m_dirty = m_valid || m_sync;
      for (int c = 0; c < NC; c++) if (m_pend[c]) m_dirty = 1'b1;
      for (int c = 0; c < NC; c++) begin
        m_sum   = m_acc[c] + m_incr[c];
        m_carry = (m_sum >= MODV);
        m_apply = m_pend[c] && (m_incr[c] == 0 || m_carry || m_sync);
        m_en[c] = m_carry && !m_sync;
        m_sq[c] = m_sync ? 1'b0 : (m_sq[c] ^ m_carry);
        m_acc[c] = (m_sync || (m_pend[c] && m_incr[c] == 0)) ? 0 : (m_sum % MODV);
        if (m_apply) begin
          m_incr[c] = m_pincr[c];
          m_pend[c] = 1'b0;
        end
        if (m_valid && int'(cfg_chan) == c) begin
          m_pincr[c] = longint'(cfg_incr);
          m_pend[c]  = 1'b1;
        end
      end
      m_streak = m_dirty ? 0 : ((m_streak < SC) ? m_streak + 1 : m_streak);
    end
  end

  logic [NC-1:0] e_en, e_sq, e_pend;
  always @(negedge refclk) begin
    for (int c = 0; c < NC; c++) begin
      e_en[c] = m_en[c]; e_sq[c] = m_sq[c]; e_pend[c] = m_pend[c];
    end
    check("model_en", longint'(outclk_en), longint'(e_en));
    check("model_sq", longint'(outclk_sq), longint'(e_sq));
    check("model_pending", longint'(pending), longint'(e_pend));
    check("model_locked", longint'(locked), longint'(m_streak >= SC));
  end

  task automatic wr(input int ch, input longint unsigned v);
    cfg_wr   = 1'b1;
    cfg_chan = 2'(ch);
    cfg_incr = AW'(v);
    @(posedge refclk);
    #1 cfg_wr = 1'b0;
  endtask

  // Edges until outclk_en[ch] is seen high; -1 if the budget runs out.
  task automatic cycles_to_en(input int ch, input int budget, output int n);
    n = 0;
    while (1) begin
      @(posedge refclk);
      #1 n++;
      if (outclk_en[ch]) break;
      if (n >= budget) begin
        n = -1;
        break;
      end
    end
  endtask

  int n, cnt, cnt1, coinc, r;

  initial begin
    repeat (3) @(posedge refclk);
    #1;
    check("rst_en", longint'(outclk_en), 0);
    check("rst_sq", longint'(outclk_sq), 0);
    check("rst_pending", longint'(pending), 0);
    check("rst_locked", longint'(locked), 0);
    check("incr_for", longint'(incr_for(64'd25, 64'd100, 32)), 64'd1 << 30);
    rst = 1'b0;

    n = 0;
    while (1) begin
      @(posedge refclk);
      #1 n++;
      if (locked || n >= 40) break;
    end
    check("lock_latency", n, 16);

    wr(0, 64'd1 << 30);
    check("pend0_set", longint'(pending[0]), 1);
    check("lock_drop", longint'(locked), 0);
    cycles_to_en(0, 20, n); check("ch0_first_strobe", n, 5);
    cycles_to_en(0, 20, n); check("ch0_period4", n, 4);

    wr(0, 64'd1 << 31);
    cycles_to_en(0, 20, n); check("ch0_old_period_done", n, 3);
    check("pend0_clear", longint'(pending[0]), 0);
    cycles_to_en(0, 20, n); check("ch0_period2", n, 2);

    wr(1, 64'd1 << 27);
    cycles_to_en(1, 100, n); check("ch1_first_strobe", n, 33);
    wr(1, 64'd1 << 29);
    wr(1, 64'd1 << 28);
    cycles_to_en(1, 100, n); check("ch1_boundary", n, 30);
    cycles_to_en(1, 100, n); check("ch1_latest_wins_period16", n, 16);

    wr(2, 64'd1 << 30);
    cycles_to_en(2, 20, n); check("ch2_first_strobe", n, 5);
    wr(2, 0);
    cycles_to_en(2, 20, n); check("ch2_last_strobe", n, 3);
    cnt = 0;
    repeat (40) begin
      @(posedge refclk);
      #1 if (outclk_en[2]) cnt++;
    end
    check("ch2_stopped", cnt, 0);
    check("ch2_pending", longint'(pending[2]), 0);

    n = 0;
    while (!locked && n < 100) begin
      @(posedge refclk);
      #1 n++;
    end
    check("relocked", longint'(locked), 1);
    cfg_wr = 1'b1; cfg_chan = 2'd3; cfg_incr = 32'd123;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge refclk);
      #1 cfg_wr = 1'b0;
      if (locked) cnt++;
    end
    check("bad_chan_lock_kept", cnt, 5);
    check("bad_chan_no_pending", longint'(pending), 0);

`ifdef PLL_CLKEN_PHASE_RESYNC_EN
    wr(0, 64'd1 << 30);
    wr(1, 64'd1 << 31);
    repeat (20) @(posedge refclk);
    #1 sync_in = 1'b1;
    @(posedge refclk);
    #1 sync_in = 1'b0;
    check("sync_sq_cleared", longint'(outclk_sq), 0);
    check("sync_en_cleared", longint'(outclk_en), 0);
    cnt = 0; cnt1 = 0; coinc = 0;
    repeat (16) begin
      @(posedge refclk);
      #1;
      if (outclk_en[0]) cnt++;
      if (outclk_en[1]) cnt1++;
      if (outclk_en[0] && outclk_en[1]) coinc++;
    end
    check("sync_ch0_strobes", cnt, 4);
    check("sync_ch1_strobes", cnt1, 8);
    check("sync_coincide", coinc, 4);
`endif

    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 99));
      if (r == 99) begin
        rst = 1'b1;
        #1;
        check("async_rst_en", longint'(outclk_en), 0);
        check("async_rst_sq", longint'(outclk_sq), 0);
        check("async_rst_locked", longint'(locked), 0);
        @(posedge refclk);
        #1 rst = 1'b0;
      end else begin
        cfg_wr = (r < 8);
        cfg_chan = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 5))
          0: cfg_incr = '0;
          1: cfg_incr = AW'(64'd1 << $urandom_range(26, 31));
          2: cfg_incr = AW'($urandom);
          3: cfg_incr = '1;
          4: cfg_incr = AW'(64'd1 << 31);
          default: cfg_incr = AW'($urandom | 32'hC000_0000);
        endcase
`ifdef PLL_CLKEN_PHASE_RESYNC_EN
        sync_in = (r == 90);
`endif
        @(posedge refclk);
        #1 cfg_wr = 1'b0;
        sync_in = 1'b0;
      end
    end

    repeat (2) @(posedge refclk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_clken_gen.md
Name: pll_clken_gen

Overview:
- Parametrised, multi-channel fractional clock-enable generator. Successor to the fixed four-output PLL wrappers.
- Runs from one PLL output clock and derives NUM_CHANNELS independent enable strobes using per-channel phase accumulators.
- Frequencies are reprogrammable at run time and switch glitch-free at period boundaries.
- Provides a lock indication compatible with the existing PLL "locked" usage. Machine-speed selection (normal/turbo, video/audio rates) drives it instead of a PLL reconfiguration.

Parameters:
- NUM_CHANNELS, 4, number of independent enable channels (1..16).
- ACC_WIDTH, 32, phase accumulator and increment width in bits; f_en = f_refclk * incr / 2^ACC_WIDTH.
- SETTLE_CYCLES, 16, refclk cycles with no pending update before locked asserts (>=1).

Ports:
- refclk  in  1  Block clock; the only clock.
- rst  in  1  Asynchronous, active-high reset.
- cfg_wr  in  1  Single-cycle write strobe for a new increment.
- cfg_chan  in  $clog2(NUM_CHANNELS) (min 1)  Target channel of cfg_wr; values >= NUM_CHANNELS are ignored.
- cfg_incr  in  ACC_WIDTH  New increment value; 0 stops the channel.
- outclk_en  out  NUM_CHANNELS  Per-channel one-cycle enable strobe.
- outclk_sq  out  NUM_CHANNELS  Per-channel square wave; toggles on each enable strobe.
- pending  out  NUM_CHANNELS  Per-channel flag: an update is written but not yet applied.
- locked  out  1  All channels stable for SETTLE_CYCLES cycles.
- sync_in  in  1  Phase resync strobe; present only with PLL_CLKEN_PHASE_RESYNC_EN.

Behaviour:
- Reset (asynchronous): every accumulator, active increment, pending increment and pending flag is cleared, so all channels are stopped. outclk_en=0, outclk_sq=0, locked=0, lock FSM enters SETTLING with counter=0.
- Per-channel datapath, each cycle:
  - {carry, acc} <= acc + incr_active, computed at ACC_WIDTH+1 bits; the sum wraps modulo 2^ACC_WIDTH.
  - outclk_en is the registered carry, so the strobe appears 1 cycle after the overflowing addition.
  - outclk_sq toggles in the cycle outclk_en is high.
- Write handling:
  - cfg_wr loads pend_incr[cfg_chan] and sets pending[cfg_chan] on the next edge.
  - A second write before the first is applied overwrites it: latest value wins, no error.
- Apply rule:
  - If pending and incr_active != 0: pend_incr moves to incr_active only on the edge where that channel's addition carries. The carrying addition itself uses the old increment; the accumulator is not cleared. No runt or stretched period.
  - If pending and incr_active == 0 (stopped channel): apply on the next edge and clear acc to 0, giving a deterministic first strobe.
  - If a write and an apply for the same channel fall in the same cycle: the applied value is the old pend_incr; the new write stays pending.
- Writing 0 stops the channel at the next boundary. outclk_sq holds its level.
- incr = 2^(ACC_WIDTH-1) gives a strobe every 2nd cycle. The maximum rate is reached at incr = 2^ACC_WIDTH-1, which strobes on nearly every cycle.
- Lock FSM:
  - States: SETTLING and LOCKED.
  - SETTLING: the counter clears whenever any pending bit or cfg_wr is high; otherwise it increments. When counter == SETTLE_CYCLES-1 on a clean cycle, go to LOCKED.
  - LOCKED: locked=1. Any cfg_wr (valid channel) returns to SETTLING with counter=0, and locked drops on the next edge.
  - After reset release with no writes, locked rises exactly SETTLE_CYCLES cycles after rst falls.

Optional Feature:
- Macro: PLL_CLKEN_PHASE_RESYNC_EN.
- Defined:
  - Port sync_in exists. On a sync_in high cycle, all accumulators are cleared to 0 and all outclk_sq are cleared to 0 on the next edge, overriding that cycle's addition.
  - Pending increments are applied simultaneously, so channels with rationally related increments are phase-aligned afterwards.
  - sync_in also restarts the lock FSM in SETTLING.
- Undefined: no sync_in port; accumulators are only affected by reset and the apply rule.

Decomposition:
- Package pll_clken_pkg:
  - lock FSM state enum (SETTLING, LOCKED);
  - helper function incr_for(freq_hz, refclk_hz, width) for testbench and software-table generation;
  - constant DEFAULT_ACC_WIDTH=32.
- Sub-module pll_clken_chan: one channel holding the accumulator, active/pending increment, apply rule, and en/sq registers. It is instantiated NUM_CHANNELS times in a generate loop. The top level holds the write decode and the lock FSM.

Test Plan:
- Reset, no writes, SETTLE_CYCLES=16 -> all outputs 0; locked rises exactly 16 cycles after rst deasserts.
- Write ch0 incr=2^30 (ACC_WIDTH=32) -> first outclk_en 4 cycles after apply, then period 4; outclk_sq period 8; locked drops, then reasserts 16 clean cycles later.
- Ch0 running at 2^30; write 2^31 mid-period -> current 4-cycle period completes unchanged, then period 2; pending[0] clears on the carry edge.
- Two writes to ch1 (2^29, then 2^28) before a carry -> only 2^28 is applied (period 16); ch0 timing is unaffected.
- Write cfg_incr=0 to running ch2 -> strobes stop after the current boundary, outclk_sq holds level; cfg_chan=NUM_CHANNELS -> no state change and locked unaffected.
- PLL_CLKEN_PHASE_RESYNC_EN: ch0=2^30, ch1=2^31, pulse sync_in -> both accumulators are 0 next cycle; both strobes coincide every 4 cycles thereafter. Asserting rst mid-run -> immediate return to reset values.
